// File: rtl/pfd_tdc_if.sv
// Signal bundle between the reference/divider clocks, the phase detector and the loop filter.
// The slave side is the detector; the master side drives the clocks and observes the results.
interface pfd_tdc_if #(
  parameter int ERR_W = 8
);
  logic                    clk_ref;
  logic                    clk_fb;
  logic                    up;
  logic                    down;
  logic signed [ERR_W-1:0] phase_err;
  logic                    err_valid;
  logic                    cycle_slip;
  logic                    locked;

  modport slave (
    input  clk_ref, clk_fb,
    output up, down, phase_err, err_valid, cycle_slip, locked
  );

  modport master (
    output clk_ref, clk_fb,
    input  up, down, phase_err, err_valid, cycle_slip, locked
  );
endinterface

// File: rtl/pfd_tdc.sv
// Digital PFD with signed time-to-digital phase error, cycle-slip flag and optional lock
// detect (enabled by defining PFD_LOCK_DETECT_EN; otherwise locked is tied low).
module pfd_tdc #(
  parameter int          SYNC_STAGES = 2,
  parameter int          ERR_W       = 8,
  parameter int unsigned LOCK_TOL    = 2,
  parameter int unsigned LOCK_CNT    = 16
) (
  input  logic       clk,
  input  logic       rst,
  pfd_tdc_if.slave   bus
);

  localparam int CNT_W = ERR_W - 1;

  if (SYNC_STAGES < 2 || ERR_W < 2 || LOCK_CNT < 1 || LOCK_TOL >= 2 ** (ERR_W - 1)) begin : g_bad_cfg
    $error("pfd_tdc: invalid parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REF_LEAD = 2'd1,
    S_FB_LEAD  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Counter is one bit narrower than the error, so the negation can never overflow.
  function automatic logic signed [ERR_W-1:0] to_err(input logic [CNT_W-1:0] c, input logic neg);
    logic signed [ERR_W-1:0] m;
    m = signed'({1'b0, c});
    return neg ? -m : m;
  endfunction

  logic [SYNC_STAGES-1:0]  r_ref_sync_p0;
  logic [SYNC_STAGES-1:0]  r_fb_sync_p0;
  logic                    r_ref_hist_p0;
  logic                    r_fb_hist_p0;
  logic                    w_ref_edge;
  logic                    w_fb_edge;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic signed [ERR_W-1:0] r_phase_err_p1;
  logic signed [ERR_W-1:0] w_phase_err_nxt;
  logic                    r_vld_p1;
  logic                    w_vld_nxt;
  logic                    r_slip_p1;
  logic                    w_slip_nxt;

  // Stage 0: synchronise both clocks into clk and derive single-cycle rising-edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_sync_p0 <= '0;
      r_fb_sync_p0  <= '0;
      r_ref_hist_p0 <= 1'b0;
      r_fb_hist_p0  <= 1'b0;
    end else begin
      r_ref_sync_p0 <= {r_ref_sync_p0[SYNC_STAGES-2:0], bus.clk_ref};
      r_fb_sync_p0  <= {r_fb_sync_p0[SYNC_STAGES-2:0], bus.clk_fb};
      r_ref_hist_p0 <= r_ref_sync_p0[SYNC_STAGES-1];
      r_fb_hist_p0  <= r_fb_sync_p0[SYNC_STAGES-1];
    end
  end

  assign w_ref_edge = r_ref_sync_p0[SYNC_STAGES-1] & ~r_ref_hist_p0;
  assign w_fb_edge  = r_fb_sync_p0[SYNC_STAGES-1] & ~r_fb_hist_p0;

  // Stage 1: lead/lag state machine, gap counter and registered measurement outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_phase_err_p1 <= '0;
      r_vld_p1       <= 1'b0;
      r_slip_p1      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_phase_err_p1 <= w_phase_err_nxt;
      r_vld_p1       <= w_vld_nxt;
      r_slip_p1      <= w_slip_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_phase_err_nxt = r_phase_err_p1;
    w_vld_nxt       = 1'b0;
    w_slip_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ref_edge && w_fb_edge) begin
          w_phase_err_nxt = '0;
          w_vld_nxt       = 1'b1;
        end else if (w_ref_edge) begin
          w_state_nxt = S_REF_LEAD;
          w_cnt_nxt   = CNT_W'(1);
        end else if (w_fb_edge) begin
          w_state_nxt = S_FB_LEAD;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_REF_LEAD: begin
        if (w_fb_edge) begin
          w_phase_err_nxt = to_err(r_cnt, 1'b0);
          w_vld_nxt       = 1'b1;
          // A coincident reference edge immediately opens the next gap.
          if (w_ref_edge) w_cnt_nxt = CNT_W'(1);
          else            w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt  = sat_inc(r_cnt);
          w_slip_nxt = w_ref_edge;
        end
      end
      S_FB_LEAD: begin
        if (w_ref_edge) begin
          w_phase_err_nxt = to_err(r_cnt, 1'b1);
          w_vld_nxt       = 1'b1;
          if (w_fb_edge) w_cnt_nxt = CNT_W'(1);
          else           w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt  = sat_inc(r_cnt);
          w_slip_nxt = w_fb_edge;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.up         = (r_state == S_REF_LEAD);
  assign bus.down       = (r_state == S_FB_LEAD);
  assign bus.phase_err  = r_phase_err_p1;
  assign bus.err_valid  = r_vld_p1;
  assign bus.cycle_slip = r_slip_p1;

`ifdef PFD_LOCK_DETECT_EN
  localparam int LK_W = $clog2(LOCK_CNT + 1);

  logic [LK_W-1:0]  r_lock_cnt_p2;
  logic             r_locked_p2;
  logic [ERR_W-1:0] w_err_abs;
  logic             w_in_tol;

  assign w_err_abs = r_phase_err_p1[ERR_W-1] ? ERR_W'(-r_phase_err_p1) : ERR_W'(r_phase_err_p1);
  assign w_in_tol  = (32'(w_err_abs) <= LOCK_TOL);

  // Stage 2: lock qualification on completed measurements
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_cnt_p2 <= '0;
      r_locked_p2   <= 1'b0;
    end else if ((r_vld_p1 && !w_in_tol) || r_slip_p1) begin
      r_lock_cnt_p2 <= '0;
      r_locked_p2   <= 1'b0;
    end else begin
      if (r_vld_p1 && (r_lock_cnt_p2 != LK_W'(LOCK_CNT))) r_lock_cnt_p2 <= r_lock_cnt_p2 + 1'b1;
      r_locked_p2 <= (r_lock_cnt_p2 == LK_W'(LOCK_CNT));
    end
  end

  assign bus.locked = r_locked_p2;
`else
  assign bus.locked = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_tdc.sv
// Randomised and directed bench for pfd_tdc: drives clk_ref/clk_fb and compares each gap
// against an arithmetic model of the expected error, pulse widths and latency.
module tb_pfd_tdc;
  localparam int ERR_W   = 8;
  localparam int SAT     = (1 << (ERR_W - 1)) - 1;
  localparam int LATENCY = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pfd_tdc_if #(.ERR_W(ERR_W)) bus ();

  pfd_tdc #(.SYNC_STAGES(2), .ERR_W(ERR_W), .LOCK_TOL(2), .LOCK_CNT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int                      cyc = 0, up_cnt = 0, down_cnt = 0, ev_cnt = 0, slip_cnt = 0;
  int                      both_cnt = 0, ev_cyc = 0;
  logic signed [ERR_W-1:0] last_err = '0;
  logic                    prev_ev = 1'b0;
  logic                    lock_after_ev = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.up) up_cnt++;
    if (bus.down) down_cnt++;
    if (bus.up && bus.down) both_cnt++;
    if (bus.cycle_slip) slip_cnt++;
    if (bus.err_valid) begin
      ev_cnt++;
      last_err = bus.phase_err;
      ev_cyc   = cyc;
    end
    if (prev_ev) lock_after_ev = bus.locked;
    prev_ev = bus.err_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_up"}, int'(bus.up), 0);
    check({tag, "_down"}, int'(bus.down), 0);
    check({tag, "_ev"}, int'(bus.err_valid), 0);
    check({tag, "_slip"}, int'(bus.cycle_slip), 0);
    check({tag, "_lock"}, int'(bus.locked), 0);
    check({tag, "_err"}, int'(bus.phase_err), 0);
  endtask

  // Model: a gap of d clk cycles (positive = reference first) yields one measurement of
  // +/-min(|d|,SAT), up or down high for |d| cycles, and err_valid LATENCY edges after the later rise.
  task automatic run_pair(input int d, input string tag);
    int b_up, b_dn, b_ev, b_slip, b_both, drive_cyc, mag, exp_err, waited;
    @(negedge clk);
    b_up = up_cnt; b_dn = down_cnt; b_ev = ev_cnt; b_slip = slip_cnt; b_both = both_cnt;
    if (d >= 0) bus.clk_ref = 1'b1; else bus.clk_fb = 1'b1;
    repeat ((d >= 0) ? d : -d) @(negedge clk);
    drive_cyc = cyc;
    if (d >= 0) bus.clk_fb = 1'b1; else bus.clk_ref = 1'b1;
    waited = 0;
    while (ev_cnt == b_ev && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    bus.clk_ref = 1'b0;
    bus.clk_fb  = 1'b0;
    repeat (6) @(negedge clk);
    mag     = (d >= 0) ? d : -d;
    exp_err = (mag > SAT) ? SAT : mag;
    if (d < 0) exp_err = -exp_err;
    check({tag, "_nvalid"}, ev_cnt - b_ev, 1);
    check({tag, "_err"}, int'(last_err), exp_err);
    check({tag, "_latency"}, ev_cyc - drive_cyc, LATENCY);
    check({tag, "_uptime"}, up_cnt - b_up, (d > 0) ? d : 0);
    check({tag, "_downtime"}, down_cnt - b_dn, (d < 0) ? -d : 0);
    check({tag, "_slips"}, slip_cnt - b_slip, 0);
    check({tag, "_overlap"}, both_cnt - b_both, 0);
  endtask

  initial begin
    int b_up, b_ev, b_slip, drive_cyc, d;
    bus.clk_ref = 1'b0;
    bus.clk_fb  = 1'b0;

    // Reset held three cycles while both inputs toggle.
    rst = 1'b1;
    @(negedge clk);
    bus.clk_ref = 1'b1; bus.clk_fb = 1'b0;
    @(negedge clk); check_idle_outputs("rst1");
    bus.clk_ref = 1'b0; bus.clk_fb = 1'b1;
    @(negedge clk); check_idle_outputs("rst2");
    bus.clk_ref = 1'b1; bus.clk_fb = 1'b1;
    @(negedge clk); check_idle_outputs("rst3");
    bus.clk_ref = 1'b0; bus.clk_fb = 1'b0;
    rst = 1'b0;
    @(negedge clk); check_idle_outputs("post_rst");
    repeat (5) @(negedge clk);
    check_idle_outputs("quiet");

    run_pair(5, "ref_lead5");
    run_pair(-3, "fb_lead3");
    run_pair(0, "simul");
    run_pair(1, "ref_lead1");
    run_pair(-1, "fb_lead1");
    run_pair(127, "sat_edge");
    run_pair(-140, "sat_neg");

    // Slip: second reference rise 100 cycles after the first, feedback 200 after the first.
    @(negedge clk);
    b_up = up_cnt; b_ev = ev_cnt; b_slip = slip_cnt;
    bus.clk_ref = 1'b1;
    repeat (50) @(negedge clk);
    bus.clk_ref = 1'b0;
    repeat (50) @(negedge clk);
    bus.clk_ref = 1'b1;
    repeat (100) @(negedge clk);
    drive_cyc = cyc;
    bus.clk_fb = 1'b1;
    repeat (10) @(negedge clk);
    bus.clk_ref = 1'b0;
    bus.clk_fb  = 1'b0;
    repeat (6) @(negedge clk);
    check("slip_count", slip_cnt - b_slip, 1);
    check("slip_nvalid", ev_cnt - b_ev, 1);
    check("slip_err", int'(last_err), SAT);
    check("slip_latency", ev_cyc - drive_cyc, LATENCY);
    check("slip_uptime", up_cnt - b_up, 200);

    // Reset mid-measurement aborts the gap without a measurement.
    @(negedge clk);
    b_up = up_cnt; b_ev = ev_cnt;
    bus.clk_ref = 1'b1;
    repeat (6) @(negedge clk);
    bus.clk_ref = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_up_before", int'(bus.up), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("abort");
    b_up = up_cnt;
    repeat (10) @(negedge clk);
    check("abort_nvalid", ev_cnt - b_ev, 0);
    check("abort_uptime", up_cnt - b_up, 0);

    for (int i = 0; i < 12; i++) begin
      d = int'($urandom_range(300)) - 150;
      run_pair(d, $sformatf("rand%0d", i));
    end

`ifdef PFD_LOCK_DETECT_EN
    for (int i = 0; i < 16; i++) begin
      check($sformatf("prelock%0d", i), int'(bus.locked), 0);
      run_pair(int'($urandom_range(4)) - 2, $sformatf("lk%0d", i));
    end
    check("locked_after16", int'(bus.locked), 1);
    run_pair(10, "unlock");
    check("unlock_next_cycle", int'(lock_after_ev), 0);
    check("unlock_held", int'(bus.locked), 0);
`else
    check("locked_tied_low", int'(bus.locked), 0);
    check("locked_after_ev", int'(lock_after_ev), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pfd_tdc.md
# pfd_tdc

Parametrised digital phase-frequency detector with time-to-digital error output. It synchronises a reference and a feedback clock into the system clock domain and drives classic UP/DOWN charge-pump-style outputs. It also measures every phase gap as a signed cycle count, flags cycle slips, and optionally reports lock. It sits between the reference/divider outputs and the digital loop filter of the all-digital PLL.

## Interface
- SYNC_STAGES, 2: synchroniser depth per input, minimum 2.
- ERR_W, 8: width of the signed `phase_err`; magnitude saturates at 2^(ERR_W-1)-1.
- LOCK_TOL, 2: maximum |phase_err| counted as "in lock" (lock detect only).
- LOCK_CNT, 16: consecutive in-tolerance measurements required to assert `locked` (lock detect only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_ref  in  1  asynchronous reference clock.
- clk_fb  in  1  asynchronous feedback (divided VCO) clock.
- up  out  1  high while the reference leads.
- down  out  1  high while the feedback leads.
- phase_err  out  ERR_W  signed gap in clk cycles; positive means the reference leads. Held between updates.
- err_valid  out  1  one-cycle pulse when `phase_err` updates.
- cycle_slip  out  1  one-cycle pulse when the leading input produces a second edge before the lagging input edges.
- locked  out  1  lock indicator; constant 0 when the lock-detect macro is not defined.

## Operation
- **Reset:** while `rst`=1 at a clk edge, all synchroniser flops, edge history, state, counter and outputs clear to 0. State is IDLE; `up`, `down`, `err_valid`, `cycle_slip`, `locked` and `phase_err` are all 0.
- **Edge detection:**
  - Each input passes through SYNC_STAGES flops plus one history flop.
  - `ref_edge`/`fb_edge` = last stage & ~history, a one-cycle pulse.
- **Counter `cnt`:** ERR_W-1 bits unsigned, saturating; it never wraps.
- **States:** IDLE, REF_LEAD, FB_LEAD.
- **IDLE:**
  - Both edges: stay in IDLE; `phase_err`=0 and `err_valid` pulses.
  - `ref_edge` only: go to REF_LEAD, `cnt`=1.
  - `fb_edge` only: go to FB_LEAD, `cnt`=1.
- **REF_LEAD:**
  - `fb_edge`: `phase_err` = +`cnt` and `err_valid` pulses.
    - If `ref_edge` arrives in the same cycle: stay in REF_LEAD with `cnt`=1.
    - Otherwise: go to IDLE.
  - `ref_edge` alone: stay in REF_LEAD, `cnt` increments (saturating), `cycle_slip` pulses.
  - Neither edge: `cnt` increments (saturating).
- **FB_LEAD:** mirror image of REF_LEAD with the roles of ref and fb swapped; `phase_err` = −`cnt`.
- **Outputs:**
  - `up` = (state==REF_LEAD) and `down` = (state==FB_LEAD). They are never both high.
  - `phase_err`, `err_valid` and `cycle_slip` are registered.

## Timing
- An input rising edge first sampled high at clk edge k produces its edge pulse in cycle k+SYNC_STAGES−1.
- An opening edge pulse in cycle N gives: state and `up`/`down` asserted from cycle N+1.
- A closing edge pulse in cycle M gives:
  - `up`/`down` deasserted in cycle M+1 (unless re-opened in the same cycle).
  - `err_valid` and the new `phase_err` present in cycle M+1.
- `up`/`down` high time equals |phase_err| cycles, until saturation.
- Saturation: `cnt` holds at 2^(ERR_W-1)-1; the reported `phase_err` is clamped to ±(2^(ERR_W-1)-1).
- `rst` asserted mid-measurement: the next cycle is IDLE with all outputs 0. No `err_valid` is generated for the aborted gap.

## Configuration
- Macro `PFD_LOCK_DETECT_EN`.
- **Defined:**
  - A lock counter increments on each `err_valid` with |phase_err| ≤ LOCK_TOL, saturating at LOCK_CNT.
  - `locked` rises the cycle after the count reaches LOCK_CNT.
  - Any `err_valid` with |phase_err| > LOCK_TOL, or any `cycle_slip`, clears the counter and `locked` the following cycle.
- **Undefined:** no lock logic is synthesised and `locked` is tied to 0.

## Test plan
Defaults apply: SYNC_STAGES=2, ERR_W=8.
- Reset: hold `rst` for 3 cycles while both clocks toggle -> all outputs 0 throughout and on the first cycle after release.
- Reference leads: `clk_ref` rises, `clk_fb` rises 5 clk later -> `up` high for exactly 5 cycles, `down`=0, `err_valid` pulse with `phase_err`=+5.
- Feedback leads: `clk_fb` leads by 3 clk -> `down` high for 3 cycles, `phase_err`=−3 (8'hFD).
- Simultaneous edges: both clocks rise in the same cycle -> `up`=`down`=0, `err_valid` with `phase_err`=0.
- Slip/saturation: two `clk_ref` rises 100 clk apart, then `clk_fb` 200 clk after the first -> one `cycle_slip` pulse, `phase_err`=+127.
- Lock (macro defined, LOCK_TOL=2, LOCK_CNT=16): 16 measurements with |err|≤2 -> `locked`=1. One measurement with err=+10 -> `locked`=0 the cycle after that `err_valid`.
